// File: rtl/cursor_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_input_ctrl
// Purpose  : Front end for the five-in-a-row board datapath. Conditions the
//            raw active-low pushbuttons (2-flop sync + debounce), moves the
//            cursor with auto-repeat, and sequences the put / gap /
//            turn_control strobes for each accepted placement. Placements on
//            occupied cells or after a win are refused.
// Ports    : clock        - system clock, all state rises on it
//            resetn       - asynchronous active-low reset
//            key_n[4:0]   - raw buttons, active low: up, down, left, right, place
//            cell_state   - board contents at coordi (00 = empty)
//            game_over    - winner reported by the board check
//            coordi[7:0]  - cursor, row in [7:4], column in [3:0]
//            put          - datapath write strobe
//            turn_control - datapath colour-toggle strobe
//            busy         - place sequencer not idle
//            reject       - one-cycle pulse on a refused placement
//            move_count   - accepted placements, saturating at 256
// Revision : 1.0 - initial release
// ============================================================================
module cursor_input_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_START  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int PULSE_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] key_n,
  input  logic [1:0] cell_state,
  input  logic       game_over,
  output logic [7:0] coordi,
  output logic       put,
  output logic       turn_control,
  output logic       busy,
  output logic       reject,
  output logic [8:0] move_count
);

  localparam int c_DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int c_REP_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
  localparam int c_P_W     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_REP_W-1:0] c_REP_START = c_REP_W'(REPEAT_START);
  localparam logic [c_REP_W-1:0] c_REP_PER   = c_REP_W'(REPEAT_PERIOD);
  localparam logic [c_P_W-1:0]   c_P_LAST    = c_P_W'(PULSE_CYCLES - 1);
  localparam logic [8:0]         c_MOVE_MAX  = 9'd256;

  // Debounced levels (1 = pressed) and one-cycle press events per key
  logic [4:0] w_pressed;
  logic [4:0] w_press_evt;
  // Press or auto-repeat events for the four direction keys
  logic [3:0] w_dir_evt;

  // --------------------------------------------------------------------------
  // Synchronizer and debounce, one instance per key
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 5; i++) begin : g_key
    logic              r_sync1;
    logic              r_sync2;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_level;
    logic              r_evt;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_sync1  <= 1'b1;
        r_sync2  <= 1'b1;
        r_db_cnt <= '0;
        r_level  <= 1'b0;
        r_evt    <= 1'b0;
      end else begin
        r_sync1 <= key_n[i];
        r_sync2 <= r_sync1;
        r_evt   <= 1'b0;
        if (~r_sync2 == r_level) begin
          // Any sample agreeing with the accepted level restarts the count
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          r_db_cnt <= '0;
          r_level  <= ~r_level;
          r_evt    <= ~r_level;  // event only on released -> pressed
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    assign w_pressed[i]   = r_level;
    assign w_press_evt[i] = r_evt;
  end

  // --------------------------------------------------------------------------
  // Auto-repeat for the direction keys. The counter holds the number of cycles
  // since the last event (press or repeat); it is 0 in the press-event cycle.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_rep
    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_started;
    logic               w_rep_fire;

    assign w_rep_fire   = w_pressed[i] &&
                          (r_rep_cnt == (r_rep_started ? c_REP_PER : c_REP_START));
    assign w_dir_evt[i] = w_press_evt[i] | w_rep_fire;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_rep_cnt     <= '0;
        r_rep_started <= 1'b0;
      end else if (!w_pressed[i]) begin
        r_rep_cnt     <= '0;
        r_rep_started <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt     <= c_REP_W'(1);
        r_rep_started <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next cursor position; opposing keys in the same cycle cancel per axis
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PUT   = 3'd2,
    S_GAP   = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  state_t           r_state;
  logic [7:0]       r_coordi;
  logic             r_put;
  logic             r_turn;
  logic             r_busy;
  logic             r_reject;
  logic [8:0]       r_move_count;
  logic [c_P_W-1:0] r_phase_cnt;

  logic [3:0] w_row_next;
  logic [3:0] w_col_next;

  always_comb begin
    w_row_next = r_coordi[7:4];
    w_col_next = r_coordi[3:0];
    if (w_dir_evt[0] && !w_dir_evt[1]) w_row_next = r_coordi[7:4] - 4'd1;
    if (w_dir_evt[1] && !w_dir_evt[0]) w_row_next = r_coordi[7:4] + 4'd1;
    if (w_dir_evt[2] && !w_dir_evt[3]) w_col_next = r_coordi[3:0] - 4'd1;
    if (w_dir_evt[3] && !w_dir_evt[2]) w_col_next = r_coordi[3:0] + 4'd1;
  end

  // --------------------------------------------------------------------------
  // Place sequencer. Strobes are driven straight from flops and only one of
  // put / turn_control can be set in any state, so they never overlap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_coordi     <= 8'h77;
      r_put        <= 1'b0;
      r_turn       <= 1'b0;
      r_busy       <= 1'b0;
      r_reject     <= 1'b0;
      r_move_count <= '0;
      r_phase_cnt  <= '0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_coordi <= {w_row_next, w_col_next};
          if (w_press_evt[4]) begin
            r_state <= S_CHECK;
            r_busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          r_phase_cnt <= '0;
          if ((cell_state != 2'b00) || game_over) begin
            r_reject <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_put   <= 1'b1;
            r_state <= S_PUT;
          end
        end
        S_PUT: begin
          if (r_phase_cnt == c_P_LAST) begin
            r_phase_cnt <= '0;
            r_put       <= 1'b0;
            r_state     <= S_GAP;
            if (r_move_count != c_MOVE_MAX) r_move_count <= r_move_count + 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_phase_cnt == c_P_LAST) begin
            r_phase_cnt <= '0;
            r_turn      <= 1'b1;
            r_state     <= S_TURN;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (r_phase_cnt == c_P_LAST) begin
            r_phase_cnt <= '0;
            r_turn      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_put       <= 1'b0;
          r_turn      <= 1'b0;
          r_busy      <= 1'b0;
          r_phase_cnt <= '0;
        end
      endcase
    end
  end

  assign coordi       = r_coordi;
  assign put          = r_put;
  assign turn_control = r_turn;
  assign busy         = r_busy;
  assign reject       = r_reject;
  assign move_count   = r_move_count;

endmodule
`default_nettype wire

// File: doc/cursor_input_ctrl.md
# cursor_input_ctrl

Upstream front end for the five-in-a-row board datapath. Turns raw active-low pushbuttons into the cursor coordinate `coordi[7:0]` (row in [7:4], column in [3:0]) and into properly sequenced `put` and `turn_control` pulses for the datapath. It also rejects placements on occupied cells or after a win. This keeps the datapath's write edge and colour toggle glitch-free and one-per-move.

## Interface
- `DB_CYCLES`, 500000: consecutive stable samples needed to accept a key level (10 ms at 50 MHz).
- `REPEAT_START`, 25000000: cycles a direction key must be held before auto-repeat begins.
- `REPEAT_PERIOD`, 10000000: cycles between auto-repeat steps.
- `PULSE_CYCLES`, 4: width in cycles of each `put` high, gap, and `turn_control` high phase; must be at least 1.
- `clock` input 1: system clock; all state rises on it.
- `resetn` input 1: asynchronous, active-low reset.
- `key_n` input 5: raw active-low buttons: [0] up, [1] down, [2] left, [3] right, [4] place.
- `cell_state` input 2: state of the cell at `coordi`, read back from board memory; 00 means empty.
- `game_over` input 1: high when the board check reports a winner.
- `coordi` output 8: cursor position; row = [7:4], column = [3:0].
- `put` output 1: write strobe to the datapath; the datapath writes on its rising edge.
- `turn_control` output 1: colour-toggle strobe to the datapath.
- `busy` output 1: high whenever the place FSM is not in IDLE.
- `reject` output 1: one-cycle pulse when a placement is refused.
- `move_count` output 9: number of accepted placements, saturating at 256.

## Operation
- **Input conditioning.** Each `key_n` bit passes through a 2-flop synchronizer, then its own debounce counter. The debounced level changes only after `DB_CYCLES` consecutive samples that differ from it; the counter clears on any sample equal to the current level.
- **Press event.** A press event is a one-cycle pulse on the debounced released→pressed transition.
- **Cursor moves (IDLE only).**
  - Up decrements row, down increments row; left decrements column, right increments column.
  - All arithmetic is mod 16: row 0 up → 15, column 15 right → 0.
- **Simultaneous direction events in one cycle.**
  - Up+down cancel, so the row is unchanged.
  - Left+right cancel, so the column is unchanged.
  - Otherwise row and column update together (diagonal move).
- **Auto-repeat.** A direction key held continuously generates its first repeat event `REPEAT_START` cycles after its press event, then one every `REPEAT_PERIOD` cycles. The repeat counter restarts on release.
- **Place FSM states.**
  - IDLE: a place press event goes to CHECK.
  - CHECK (1 cycle): samples `cell_state` and `game_over`.
    - If `cell_state`≠00 or `game_over`=1: pulse `reject` and return to IDLE.
    - Otherwise go to PUT.
  - PUT: `put`=1 for `PULSE_CYCLES` cycles, then go to GAP.
  - GAP: all strobes 0 for `PULSE_CYCLES` cycles. `move_count` increments (saturating) on GAP entry. Then go to TURN.
  - TURN: `turn_control`=1 for `PULSE_CYCLES` cycles, then return to IDLE.
- **Events while not in IDLE.**
  - Direction and place events are dropped, not queued.
  - `coordi` is frozen from CHECK through TURN.
  - Auto-repeat counters keep running, but their events are dropped too.
- **Output glitch rule.** `put` and `turn_control` come directly from flops; they are never both high.

## Timing
- **Reset values.** `coordi`=8'h77, `put`=0, `turn_control`=0, `busy`=0, `reject`=0, `move_count`=0. FSM in IDLE; all debounced levels "released"; all counters 0.
- **Reset mid-operation** (any state) forces the values above immediately. No further strobe occurs after release.
- **Press latency.** Raw key edge → press event takes 2 sync cycles + `DB_CYCLES`. `coordi` changes in the cycle after the event.
- **Place sequence,** counting the place event at cycle 0:
  - CHECK at cycle 1.
  - `put` high cycles 2..1+P.
  - Gap cycles 2+P..1+2P.
  - `turn_control` high cycles 2+2P..1+3P.
  - IDLE at cycle 2+3P.
  - P = `PULSE_CYCLES`.
- **Reject sequence.** `reject` is high in cycle 2 only; back in IDLE at cycle 2. `busy` is high in cycle 1.
- **Move-count saturation.** At 256, further accepted moves still strobe `put`/`turn_control` but leave the count unchanged.

## Test plan
Bench parameters: `DB_CYCLES`=4, `REPEAT_START`=20, `REPEAT_PERIOD`=8, `PULSE_CYCLES`=3.

- **Debounce and wrap:** after reset `coordi`=8'h77; press up cleanly 8 times → `coordi`=8'hF7. Bounce `key_n[0]` every 2 cycles for 40 cycles → no change.
- **Auto-repeat:** hold right from 8'h7F for 40 cycles after its press event → events at 0, 20, 28, 36 → `coordi`=8'h73. Press up+down together → no row change.
- **Accepted place:** `cell_state`=00, place press → `put` high exactly cycles 2–4, `turn_control` high exactly cycles 8–10, `move_count` 0→1. Never both strobes high.
- **Rejects:** `cell_state`=01 → `reject` pulses once, `put` and `turn_control` stay 0. Repeat with `cell_state`=00 and `game_over`=1 → same result.
- **Busy drop:** press left during PUT → `coordi` unchanged after the sequence. A second place press during GAP → only one `put` pulse.
- **Async reset:** assert `resetn`=0 while `put`=1 → `put` drops immediately. `coordi`=8'h77 and `move_count`=0. No `turn_control` pulse after reset is released.
